// File: rtl/seq_mul_div_pkg.sv
// Shared ALU opcode constants and the mul/div sequencer state encoding.
// Also imported by the ALU and the control unit.
package seq_mul_div_pkg;

   localparam int OPC_W = 5;

   localparam logic [OPC_W-1:0] OP_MUL = 5'b10000;
   localparam logic [OPC_W-1:0] OP_DIV = 5'b01111;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_DZ   = 3'd3,
      ST_FIX  = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   function automatic logic is_muldiv(input logic [OPC_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/seq_mul_div_if.sv
// Request/result bundle between the control unit (master) and the mul/div unit (slave).
interface seq_mul_div_if
   import seq_mul_div_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic             start;
   logic [OPC_W-1:0] opcode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;

   modport master (
      output start, opcode, A, B,
      input  busy, done, div_zero, hi_out, lo_out
   );

   modport slave (
      input  start, opcode, A, B,
      output busy, done, div_zero, hi_out, lo_out
   );

endinterface

// File: rtl/seq_mul_div_nrdiv_step.sv
// One non-restoring division iteration on unsigned magnitudes.
// The remainder is kept one bit wider than the divisor so its sign is explicit.
module seq_mul_div_nrdiv_step
   import seq_mul_div_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic signed [WIDTH:0]   rem_i,
   input  logic        [WIDTH-1:0] quot_i,
   input  logic        [WIDTH-1:0] dvs_i,
   output logic signed [WIDTH:0]   rem_o,
   output logic        [WIDTH-1:0] quot_o
);

   logic signed [WIDTH:0] shifted;
   logic signed [WIDTH:0] dvs_ext;

   // The remainder stays in [-D, D), so dropping its top bit on the shift loses nothing.
   assign shifted = {rem_i[WIDTH-1:0], quot_i[WIDTH-1]};
   assign dvs_ext = {1'b0, dvs_i};

   assign rem_o  = rem_i[WIDTH] ? (shifted + dvs_ext) : (shifted - dvs_ext);
   assign quot_o = {quot_i[WIDTH-2:0], ~rem_o[WIDTH]};

endmodule

// File: rtl/seq_mul_div.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring), one iteration per clock.
// Results are published only on entry to DONE, so hi_out/lo_out never show partial values.
module seq_mul_div
   import seq_mul_div_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic         clock,
   input  logic         clear,
   seq_mul_div_if.slave bus
);

   localparam int              CNT_W   = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

   state_t state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             dz_q, dz_d;

   // acc doubles as the signed partial remainder, q as multiplier / dividend-then-quotient.
   logic signed [WIDTH:0] acc_q, acc_d;
   logic signed [WIDTH:0] m_q, m_d;
   logic [WIDTH-1:0]      q_q, q_d;
   logic                  q1_q, q1_d;
   logic                  qneg_q, qneg_d;
   logic                  rneg_q, rneg_d;

   logic                  accept;
   logic                  b_zero;
   logic                  last_it;
   logic signed [WIDTH:0] booth_sum;
   logic signed [WIDTH:0] step_rem;
   logic [WIDTH-1:0]      step_quot;
   logic [WIDTH-1:0]      rem_fix;

   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return neg_if(v, v[WIDTH-1]);
   endfunction

   assign accept  = (state_q == ST_IDLE) && bus.start && is_muldiv(bus.opcode);
   assign b_zero  = (bus.B == '0);
   assign last_it = (cnt_q == LAST_IT);

   always_comb begin
      booth_sum = acc_q;
      case ({q_q[0], q1_q})
         2'b01:   booth_sum = acc_q + m_q;
         2'b10:   booth_sum = acc_q - m_q;
         default: booth_sum = acc_q;
      endcase
   end

   seq_mul_div_nrdiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i  (acc_q),
      .quot_i (q_q),
      .dvs_i  (m_q[WIDTH-1:0]),
      .rem_o  (step_rem),
      .quot_o (step_quot)
   );

   // A negative final remainder is restored modulo 2^WIDTH; the true value is in [0, D).
   assign rem_fix = acc_q[WIDTH] ? (acc_q[WIDTH-1:0] + m_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

   always_ff @(posedge clock or posedge clear) begin
      if (clear) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (bus.opcode == OP_MUL) state_d = ST_MUL;
               else if (b_zero)          state_d = ST_DZ;
               else                      state_d = ST_DIV;
            end
         end
         ST_MUL:  if (last_it) state_d = ST_DONE;
         ST_DIV:  if (last_it) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         ST_DZ:   state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bus.busy     = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                     (state_q == ST_DZ)  || (state_q == ST_FIX);
      bus.done     = (state_q == ST_DONE);
      bus.div_zero = dz_q;
      bus.hi_out   = hi_q;
      bus.lo_out   = lo_q;
   end

   always_comb begin
      acc_d  = acc_q;
      m_d    = m_q;
      q_d    = q_q;
      q1_d   = q1_q;
      qneg_d = qneg_q;
      rneg_d = rneg_q;
      cnt_d  = '0;
      hi_d   = hi_q;
      lo_d   = lo_q;
      dz_d   = dz_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               acc_d  = '0;
               q1_d   = 1'b0;
               dz_d   = 1'b0;
               qneg_d = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
               rneg_d = bus.A[WIDTH-1];
               if (bus.opcode == OP_MUL) begin
                  m_d = {bus.A[WIDTH-1], bus.A};
                  q_d = bus.B;
               end else begin
                  // Magnitudes as unsigned WIDTH-bit values, so -2^(W-1) maps to 2^(W-1).
                  m_d = {1'b0, mag(bus.B)};
                  q_d = b_zero ? bus.A : mag(bus.A);
               end
            end
         end
         ST_MUL: begin
            acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + 1'b1;
            if (last_it) begin
               hi_d = booth_sum[WIDTH:1];
               lo_d = {booth_sum[0], q_q[WIDTH-1:1]};
            end
         end
         ST_DIV: begin
            acc_d = step_rem;
            q_d   = step_quot;
            cnt_d = cnt_q + 1'b1;
         end
         ST_FIX: begin
            hi_d = neg_if(rem_fix, rneg_q);
            lo_d = neg_if(q_q, qneg_q);
         end
         ST_DZ: begin
            hi_d = q_q;
            lo_d = '1;
            dz_d = 1'b1;
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         dz_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         dz_q  <= dz_d;
      end
   end

   // Working registers are fully reloaded on every accept, so they need no reset.
   always_ff @(posedge clock) begin
      acc_q  <= acc_d;
      m_q    <= m_d;
      q_q    <= q_d;
      q1_q   <= q1_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
   end

endmodule

// File: tb/tb_seq_mul_div.sv
// Self-checking bench for seq_mul_div: vector table, random ops against a 64-bit model,
// and hand-written sequences for ignored starts, bad opcodes and mid-operation clear.
module tb_seq_mul_div;

   localparam int         W   = 32;
   localparam logic [4:0] OPM = 5'b10000;
   localparam logic [4:0] OPD = 5'b01111;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic clr;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];
   vec_t tbl[16];

   seq_mul_div_if #(.WIDTH(W)) bus();

   seq_mul_div #(.WIDTH(W)) dut (
      .clock (clk),
      .clear (clr),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      vec_t   v;
      longint sa, sbv, r;
      logic [63:0] bits;
      v.op = op; v.a = a; v.b = b; v.dz = 1'b0;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (op == OPM) begin
         r = sa * sbv; bits = r;
         v.hi = bits[63:32]; v.lo = bits[31:0];
      end else if (b == 32'h0) begin
         v.hi = a; v.lo = 32'hFFFF_FFFF; v.dz = 1'b1;
      end else begin
         r = sa / sbv; bits = r; v.lo = bits[31:0];
         r = sa % sbv; bits = r; v.hi = bits[31:0];
      end
      return v;
   endfunction

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   // Issue one op; inj_k >= 1 re-pulses start with other operands at that cycle after accept.
   task automatic run_op(input string tag, input vec_t v, input int inj_k);
      exp_t e, got;
      int   k;
      int   busy_n;
      bit   seen;
      e.hi  = v.hi; e.lo = v.lo; e.dz = v.dz;
      e.lat = (v.op == OPM) ? 33 : ((v.b == 32'h0) ? 2 : 34);
      bus.start = 1'b1; bus.opcode = v.op; bus.A = v.a; bus.B = v.b;
      sample();
      bus.start = 1'b0;
      sb.push_back(e);
      chk({tag, ".dz_after_accept"}, 64'(bus.div_zero), 64'(0));
      seen = 1'b0; busy_n = 0;
      for (k = 1; k <= 80 && !seen; k++) begin
         if (k == inj_k) begin
            bus.start = 1'b1; bus.opcode = OPD; bus.A = 32'd100; bus.B = 32'd3;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            seen = 1'b1;
            if (sb.size() == 0) begin
               chk({tag, ".unexpected_done"}, 64'(1), 64'(0));
            end else begin
               got = sb.pop_front();
               chk({tag, ".hi"}, 64'(bus.hi_out), 64'(got.hi));
               chk({tag, ".lo"}, 64'(bus.lo_out), 64'(got.lo));
               chk({tag, ".div_zero"}, 64'(bus.div_zero), 64'(got.dz));
               chk({tag, ".latency"}, 64'(k), 64'(got.lat));
               chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(got.lat - 1));
               chk({tag, ".busy_at_done"}, 64'(bus.busy), 64'(0));
            end
         end else begin
            if (bus.busy) busy_n++;
            sample();
         end
      end
      if (!seen) begin
         chk({tag, ".timeout"}, 64'(0), 64'(1));
         if (sb.size() != 0) void'(sb.pop_front());
      end
      sample();
      bus.start = 1'b0;
      chk({tag, ".done_pulse_width"}, 64'(bus.done), 64'(0));
      chk({tag, ".idle_after"}, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      bit got_done;
      vec_t v;

      tbl[0]  = '{OPM, 32'd6,          32'd7,          32'h0000_0000, 32'h0000_002A, 1'b0};
      tbl[1]  = '{OPM, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
      tbl[2]  = '{OPM, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0};
      tbl[3]  = '{OPD, 32'd5,          32'd0,          32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
      tbl[4]  = '{OPM, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
      tbl[5]  = '{OPM, 32'h8000_0000,  32'h7FFF_FFFF,  32'hC000_0000, 32'h8000_0000, 1'b0};
      tbl[6]  = '{OPM, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, 1'b0};
      tbl[7]  = '{OPD, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tbl[8]  = '{OPD, 32'd100,        32'd7,          32'h0000_0002, 32'h0000_000E, 1'b0};
      tbl[9]  = '{OPD, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0};
      tbl[10] = '{OPD, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
      tbl[11] = '{OPD, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE, 32'h0000_0002, 1'b0};
      tbl[12] = '{OPD, 32'h7FFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF, 32'h0000_0000, 1'b0};
      tbl[13] = '{OPD, 32'h8000_0000,  32'd7,          32'hFFFF_FFFE, 32'hEDB6_DB6E, 1'b0};
      tbl[14] = '{OPD, 32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1};
      tbl[15] = '{OPD, 32'd3,          32'd7,          32'h0000_0003, 32'h0000_0000, 1'b0};

      clr = 1'b1; bus.start = 1'b0; bus.opcode = 5'd0; bus.A = 32'd0; bus.B = 32'd0;
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      sample();
      chk("reset.busy", 64'(bus.busy), 64'(0));
      chk("reset.done", 64'(bus.done), 64'(0));
      chk("reset.div_zero", 64'(bus.div_zero), 64'(0));
      chk("reset.hi", 64'(bus.hi_out), 64'(0));
      chk("reset.lo", 64'(bus.lo_out), 64'(0));

      for (int i = 0; i < 16; i++) run_op($sformatf("vec%0d", i), tbl[i], 0);

      for (int i = 0; i < 10; i++) begin
         v = model(($urandom_range(0, 1) == 1) ? OPM : OPD, $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom);
         run_op($sformatf("rnd%0d", i), v, 0);
      end

      // Start pulses while busy and while in DONE must not disturb the running op.
      run_op("ign_mid_mul", tbl[0], 5);
      run_op("ign_in_done", tbl[8], 34);

      bus.start = 1'b1; bus.opcode = 5'b00011; bus.A = 32'd1; bus.B = 32'd2;
      sample();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("badop.busy", 64'(bus.busy), 64'(0));
         chk("badop.done", 64'(bus.done), 64'(0));
         sample();
      end

      // Abort a divide part-way through with clear.
      run_op("pre_clear_dz", tbl[3], 0);
      bus.start = 1'b1; bus.opcode = OPD; bus.A = 32'd100; bus.B = 32'd7;
      sample();
      bus.start = 1'b0;
      repeat (9) sample();
      clr = 1'b1;
      sample();
      chk("clear.busy", 64'(bus.busy), 64'(0));
      chk("clear.done", 64'(bus.done), 64'(0));
      chk("clear.div_zero", 64'(bus.div_zero), 64'(0));
      chk("clear.hi", 64'(bus.hi_out), 64'(0));
      chk("clear.lo", 64'(bus.lo_out), 64'(0));
      clr = 1'b0;
      got_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done || bus.busy) got_done = 1'b1;
         sample();
      end
      chk("clear.no_done_after_abort", 64'(got_done), 64'(0));
      chk("clear.hi_held", 64'(bus.hi_out), 64'(0));
      run_op("post_clear_div", tbl[8], 0);
      run_op("post_clear_mul", tbl[1], 0);

      chk("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
